// File: rtl/ones_counter_seq.sv
// ----------------------------------------------------------------------------
// ones_counter_seq
//   Sequential population counter. Accepts a WIDTH-bit word over a valid/ready
//   handshake, counts its set bits CHUNK bits per cycle, returns the count over
//   a valid/ready output handshake and keeps a saturating running total of all
//   delivered counts.
//
// Parameters
//   WIDTH    input word width (multiple of CHUNK)
//   CHUNK    bits examined per COUNT cycle
//   TOTAL_W  running-total width
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     producer has a word
//   in_ready     block can accept a word (IDLE only)
//   in_data      word to count, sampled only on the accept cycle
//   out_valid    count result available (DONE)
//   out_ready    consumer accepts result
//   out_count    number of ones in the accepted word
//   total_clr    synchronous clear of total_count / total_sat (wins over add)
//   total_count  saturating sum of delivered out_count values
//   total_sat    sticky saturation flag
//   out_parity   odd parity of the word (only with ONES_COUNTER_PARITY_EN)
//
// Build option
//   `define ONES_COUNTER_PARITY_EN adds the out_parity output.
// ----------------------------------------------------------------------------
module ones_counter_seq #(
   parameter int WIDTH   = 8,
   parameter int CHUNK   = 2,
   parameter int TOTAL_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] out_count,
   input  logic                       total_clr,
   output logic [TOTAL_W-1:0]         total_count,
   output logic                       total_sat
`ifdef ONES_COUNTER_PARITY_EN
   ,
   output logic                       out_parity
`endif
);

   localparam int CNT_W  = $clog2(WIDTH+1);
   localparam int NBEATS = WIDTH / CHUNK;
   // Keep the beat counter at least one bit wide when a single beat suffices.
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(NBEATS - 1);
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [CNT_W-1:0]    acc_q,   acc_d;
   logic [BEAT_W-1:0]   beat_q,  beat_d;
   logic [TOTAL_W-1:0]  total_q, total_d;
   logic                sat_q,   sat_d;

   logic [CNT_W-1:0]    beat_pop;
   logic [TOTAL_W:0]    total_sum;

   // Popcount of the low CHUNK bits, zero-extended to the accumulator width.
   always_comb begin
      beat_pop = '0;
      for (int i = 0; i < CHUNK; i++) begin
         beat_pop = beat_pop + CNT_W'(shift_q[i]);
      end
   end

   // One extra bit catches the carry out that signals a clamp.
   assign total_sum = {1'b0, total_q} + (TOTAL_W+1)'(acc_q);

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      acc_d     = acc_q;
      beat_d    = beat_q;
      total_d   = total_q;
      sat_d     = sat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_d = in_data;
               acc_d   = '0;
               beat_d  = '0;
               state_d = S_COUNT;
            end
         end

         S_COUNT: begin
            acc_d   = acc_q + beat_pop;
            shift_d = shift_q >> CHUNK;
            beat_d  = beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) begin
               beat_d  = '0;
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = S_IDLE;
               if (total_sum[TOTAL_W]) begin
                  total_d = TOTAL_MAX;
                  sat_d   = 1'b1;
               end else begin
                  total_d = total_sum[TOTAL_W-1:0];
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Clear overrides any add on the same edge.
      if (total_clr) begin
         total_d = '0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         acc_q   <= '0;
         beat_q  <= '0;
         total_q <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         beat_q  <= beat_d;
         total_q <= total_d;
         sat_q   <= sat_d;
      end
   end

   // The accumulator is frozen throughout DONE, so it drives the result directly.
   assign out_count   = acc_q;
   assign total_count = total_q;
   assign total_sat   = sat_q;

`ifdef ONES_COUNTER_PARITY_EN
   assign out_parity = acc_q[0];
`endif

endmodule

// File: tb/tb_ones_counter_seq.sv
// ----------------------------------------------------------------------------
// tb_ones_counter_seq
//   Two instances share all inputs: A (TOTAL_W=16) and B (TOTAL_W=4, to reach
//   saturation quickly). A table of directed words is followed by random words,
//   a mid-count reset, a full 0..255 sweep and saturation/clear sequences.
// ----------------------------------------------------------------------------
module tb_ones_counter_seq;

   localparam int NB = 4;   // WIDTH/CHUNK for 8/2

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;
   logic       total_clr;

   logic        in_ready_a, out_valid_a, sat_a;
   logic [3:0]  cnt_a;
   logic [15:0] tot_a;
   logic        in_ready_b, out_valid_b, sat_b;
   logic [3:0]  cnt_b;
   logic [3:0]  tot_b;
`ifdef ONES_COUNTER_PARITY_EN
   logic        par_a, par_b;
`endif

   int errors = 0;
   int checks = 0;

   // Reference totals
   longint m_tot_a, m_tot_b;
   bit     m_sat_a, m_sat_b;

   always #5 clk = ~clk;

   ones_counter_seq #(.WIDTH(8), .CHUNK(2), .TOTAL_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_count(cnt_a),
      .total_clr(total_clr), .total_count(tot_a), .total_sat(sat_a)
`ifdef ONES_COUNTER_PARITY_EN
      , .out_parity(par_a)
`endif
   );

   ones_counter_seq #(.WIDTH(8), .CHUNK(2), .TOTAL_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_count(cnt_b),
      .total_clr(total_clr), .total_count(tot_b), .total_sat(sat_b)
`ifdef ONES_COUNTER_PARITY_EN
      , .out_parity(par_b)
`endif
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_add(input int cnt);
      m_tot_a = (m_tot_a + cnt > 65535) ? 65535 : m_tot_a + cnt;
      if (m_tot_a == 65535 && cnt != 0 && m_tot_a - cnt < 0) m_sat_a = 1'b1;
      m_sat_a = m_sat_a;
   endtask

   task automatic model_deliver(input int cnt);
      if (m_tot_a + cnt > 65535) begin m_tot_a = 65535; m_sat_a = 1'b1; end
      else m_tot_a = m_tot_a + cnt;
      if (m_tot_b + cnt > 15) begin m_tot_b = 15; m_sat_b = 1'b1; end
      else m_tot_b = m_tot_b + cnt;
   endtask

   task automatic model_clear();
      m_tot_a = 0; m_tot_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
   endtask

   task automatic check_totals(input string tag);
      check({tag, "_total_a"}, tot_a, m_tot_a);
      check({tag, "_sat_a"},   sat_a, m_sat_a);
      check({tag, "_total_b"}, tot_b, m_tot_b);
      check({tag, "_sat_b"},   sat_b, m_sat_b);
   endtask

   // Entered and left at a negedge. Accepts one word, checks latency, holds
   // the result for 'hold' cycles, then completes one output handshake
   // (optionally with total_clr asserted on that same edge).
   task automatic send_word(input logic [7:0] d, input int exp_cnt,
                            input int hold, input bit clr_hs);
      int e;
      int g;
      g = 0;
      while (!in_ready_a && g < 20) begin @(negedge clk); g++; end
      check("in_ready_idle", in_ready_a, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      e = 0;
      while (!out_valid_a && e < 20) begin
         check("in_ready_busy", in_ready_a, 0);
         @(posedge clk);
         @(negedge clk);
         in_data = 8'($urandom);
         e++;
      end
      check("latency_edges", e, NB);
      check("out_count_a", cnt_a, exp_cnt);
      check("out_count_b", cnt_b, exp_cnt);
`ifdef ONES_COUNTER_PARITY_EN
      check("out_parity", par_a, exp_cnt % 2);
`endif
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", out_valid_a, 1);
         check("hold_count", cnt_a, exp_cnt);
         check("hold_in_ready", in_ready_a, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total_clr = clr_hs;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      total_clr = 1'b0;
      if (clr_hs) model_clear();
      else        model_deliver(exp_cnt);
      check("post_hs_valid", out_valid_a, 0);
      check("post_hs_in_ready", in_ready_a, 1);
      check_totals("post_hs");
   endtask

   typedef struct {
      logic [7:0] d;
      int         hold;
      bit         clr;
      int         exp;
   } vec_t;

   vec_t tbl[9];

   initial begin
      logic [7:0] r;

      tbl[0] = '{8'h00, 0,  1'b0, 0};
      tbl[1] = '{8'hFF, 0,  1'b0, 8};
      tbl[2] = '{8'hA5, 2,  1'b0, 4};
      tbl[3] = '{8'h3C, 10, 1'b0, 4};
      tbl[4] = '{8'h07, 1,  1'b0, 3};
      tbl[5] = '{8'h80, 0,  1'b0, 1};
      tbl[6] = '{8'h55, 3,  1'b1, 4};   // clear coincides with handshake
      tbl[7] = '{8'hFE, 0,  1'b0, 7};
      tbl[8] = '{8'h01, 0,  1'b0, 1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; total_clr = 1'b0;
      model_clear();
      #1;
      check("rst_in_ready", in_ready_a, 1);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_out_count", cnt_a, 0);
      check_totals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 9; i++) begin
         send_word(tbl[i].d, tbl[i].exp, tbl[i].hold, tbl[i].clr);
      end
      // FF then A5 from a cleared total gives 12
      total_clr = 1'b1; @(negedge clk); total_clr = 1'b0; model_clear();
      send_word(8'hFF, 8, 0, 1'b0);
      send_word(8'hA5, 4, 0, 1'b0);
      check("sum_ff_a5", tot_a, 12);

      // Random words against the reference model
      for (int i = 0; i < 30; i++) begin
         r = 8'($urandom);
         send_word(r, $countones(r), int'($urandom_range(0, 3)), 1'b0);
      end

      // Reset during COUNT aborts the word
      in_valid = 1'b1; in_data = 8'hF0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_clear();
      check("midrst_in_ready", in_ready_a, 1);
      check("midrst_out_valid", out_valid_a, 0);
      check("midrst_out_count", cnt_a, 0);
      check_totals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (NB + 2) begin
         @(negedge clk);
         check("midrst_no_output", out_valid_a, 0);
      end
      send_word(8'h01, 1, 0, 1'b0);

      // Full sweep from a cleared total
      total_clr = 1'b1; @(negedge clk); total_clr = 1'b0; model_clear();
      check_totals("clr_pulse");
      for (int v = 0; v < 256; v++) begin
         r = 8'(v);
         send_word(r, $countones(r), 0, 1'b0);
      end
      check("sweep_total", tot_a, 1024);
      check("sweep_sat_b", sat_b, 1);

      // Small total saturates after two full words, then clears
      total_clr = 1'b1; @(negedge clk); total_clr = 1'b0; model_clear();
      send_word(8'hFF, 8, 0, 1'b0);
      check("sat_b_first", sat_b, 0);
      send_word(8'hFF, 8, 0, 1'b0);
      check("sat_total_b", tot_b, 15);
      check("sat_flag_b", sat_b, 1);
      send_word(8'h00, 0, 0, 1'b0);
      check("sat_sticky_b", sat_b, 1);
      total_clr = 1'b1; @(negedge clk); total_clr = 1'b0; model_clear();
      check("clr_total_b", tot_b, 0);
      check("clr_sat_b", sat_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
